tap_controller: RTL and testbench

16-state IEEE 1149.1 TAP state machine for the JTAG block. Samples TMS on rising TCK and decodes the current state into the capture/shift/update strobes for the instruction and data registers. Sits directly upstream of the DR/IR TDO multiplexer: its SEL output drives the mux select, and its ENABLE output gates the pad driven by the mux output TDO.

---
 rtl/tap_controller.sv | 85 ++++++++
 tb/tb_tap_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine: samples tms on rising tck and decodes the
// current state into IR/DR capture/shift/update strobes, TDO mux select and enable.
module tap_controller (
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output logic [3:0] state,
  output logic       tlr,
  output logic       sel,
  output logic       enable,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  localparam logic [3:0] TEST_LOGIC_RESET = 4'hF;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'hC;
  localparam logic [3:0] SELECT_DR        = 4'h7;
  localparam logic [3:0] CAPTURE_DR       = 4'h6;
  localparam logic [3:0] SHIFT_DR         = 4'h2;
  localparam logic [3:0] EXIT1_DR         = 4'h1;
  localparam logic [3:0] PAUSE_DR         = 4'h3;
  localparam logic [3:0] EXIT2_DR         = 4'h0;
  localparam logic [3:0] UPDATE_DR        = 4'h5;
  localparam logic [3:0] SELECT_IR        = 4'h4;
  localparam logic [3:0] CAPTURE_IR       = 4'hE;
  localparam logic [3:0] SHIFT_IR         = 4'hA;
  localparam logic [3:0] EXIT1_IR         = 4'h9;
  localparam logic [3:0] PAUSE_IR         = 4'hB;
  localparam logic [3:0] EXIT2_IR         = 4'h8;
  localparam logic [3:0] UPDATE_IR        = 4'hD;

  logic [3:0] state_reg;
  logic [3:0] state_next;

  always_ff @(posedge tck or posedge rst) begin
    if (rst) state_reg <= TEST_LOGIC_RESET;
    else     state_reg <= state_next;
  end

  // All 16 encodings are legal states, so the case is fully covered.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_next = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    state      = state_reg;
    tlr        = (state_reg == TEST_LOGIC_RESET);
    capture_dr = (state_reg == CAPTURE_DR);
    shift_dr   = (state_reg == SHIFT_DR);
    update_dr  = (state_reg == UPDATE_DR);
    capture_ir = (state_reg == CAPTURE_IR);
    shift_ir   = (state_reg == SHIFT_IR);
    update_ir  = (state_reg == UPDATE_IR);
    enable     = shift_dr | shift_ir;
    // IR-side states: SELECT_IR through UPDATE_IR steer the TDO mux to the IR.
    sel = (state_reg == SELECT_IR) || (state_reg == CAPTURE_IR) ||
          (state_reg == SHIFT_IR)  || (state_reg == EXIT1_IR)   ||
          (state_reg == PAUSE_IR)  || (state_reg == EXIT2_IR)   ||
          (state_reg == UPDATE_IR);
  end

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: vector tables for DR/IR scans plus
// hand-written sequences for reset, TMS-reset and hold-state corner cases.
module tb_tap_controller;

  logic       tck = 1'b0;
  logic       rst = 1'b1;
  logic       tms = 1'b1;
  logic [3:0] state;
  logic       tlr, sel, enable;
  logic       capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir;

  int n_checks = 0;
  int n_fail   = 0;

  tap_controller dut (
    .tck(tck), .rst(rst), .tms(tms), .state(state),
    .tlr(tlr), .sel(sel), .enable(enable),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir)
  );

  always #5 tck = ~tck;

  // flags = {tlr, sel, enable, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir}
  typedef struct {
    logic       tms;
    logic [3:0] exp_state;
    logic [8:0] exp_flags;
  } vec_t;

  typedef struct {
    int         len;
    logic [7:0] bits;   // bit 0 applied first, starting from TEST_LOGIC_RESET
    logic [3:0] target;
  } path_t;

  vec_t  dr_vec [8];
  vec_t  ir_vec [11];
  path_t paths  [16];

  function automatic logic [8:0] exp_flags(input logic [3:0] s);
    case (s)
      4'hF:    return 9'b100000000;
      4'h6:    return 9'b000100000;
      4'h2:    return 9'b001010000;
      4'h5:    return 9'b000001000;
      4'h4, 4'h9, 4'hB, 4'h8: return 9'b010000000;
      4'hE:    return 9'b010000100;
      4'hA:    return 9'b011000010;
      4'hD:    return 9'b010000001;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] es, input logic [8:0] ef);
    logic [8:0] af;
    af = {tlr, sel, enable, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir};
    n_checks++;
    if (state !== es || af !== ef) begin
      n_fail++;
      $display("FAIL %s: state=%h flags=%b, expected state=%h flags=%b", name, state, af, es, ef);
    end else begin
      $display("ok   %s: state=%h flags=%b", name, state, af);
    end
  endtask

  task automatic step(input logic v);
    tms = v;
    @(posedge tck);
    #1;
  endtask

  task automatic walk(input path_t p);
    for (int i = 0; i < p.len; i++) step(p.bits[i]);
  endtask

  task automatic tms_reset();
    for (int i = 0; i < 5; i++) step(1'b1);
  endtask

  initial begin
    dr_vec[0] = '{1'b1, 4'h7, 9'b000000000};
    dr_vec[1] = '{1'b0, 4'h6, 9'b000100000};
    dr_vec[2] = '{1'b0, 4'h2, 9'b001010000};
    dr_vec[3] = '{1'b0, 4'h2, 9'b001010000};
    dr_vec[4] = '{1'b0, 4'h2, 9'b001010000};
    dr_vec[5] = '{1'b1, 4'h1, 9'b000000000};
    dr_vec[6] = '{1'b1, 4'h5, 9'b000001000};
    dr_vec[7] = '{1'b0, 4'hC, 9'b000000000};

    ir_vec[0]  = '{1'b1, 4'h7, 9'b000000000};
    ir_vec[1]  = '{1'b1, 4'h4, 9'b010000000};
    ir_vec[2]  = '{1'b0, 4'hE, 9'b010000100};
    ir_vec[3]  = '{1'b0, 4'hA, 9'b011000010};
    ir_vec[4]  = '{1'b1, 4'h9, 9'b010000000};
    ir_vec[5]  = '{1'b0, 4'hB, 9'b010000000};
    ir_vec[6]  = '{1'b1, 4'h8, 9'b010000000};
    ir_vec[7]  = '{1'b0, 4'hA, 9'b011000010};
    ir_vec[8]  = '{1'b1, 4'h9, 9'b010000000};
    ir_vec[9]  = '{1'b1, 4'hD, 9'b010000001};
    ir_vec[10] = '{1'b0, 4'hC, 9'b000000000};

    paths[0]  = '{0, 8'b00000000, 4'hF};
    paths[1]  = '{1, 8'b00000000, 4'hC};
    paths[2]  = '{2, 8'b00000010, 4'h7};
    paths[3]  = '{3, 8'b00000010, 4'h6};
    paths[4]  = '{4, 8'b00000010, 4'h2};
    paths[5]  = '{4, 8'b00001010, 4'h1};
    paths[6]  = '{5, 8'b00001010, 4'h3};
    paths[7]  = '{6, 8'b00101010, 4'h0};
    paths[8]  = '{5, 8'b00011010, 4'h5};
    paths[9]  = '{3, 8'b00000110, 4'h4};
    paths[10] = '{4, 8'b00000110, 4'hE};
    paths[11] = '{5, 8'b00000110, 4'hA};
    paths[12] = '{5, 8'b00010110, 4'h9};
    paths[13] = '{6, 8'b00010110, 4'hB};
    paths[14] = '{7, 8'b01010110, 4'h8};
    paths[15] = '{6, 8'b00110110, 4'hD};

    // Reset state while rst is held, then released between edges.
    #12;
    check("reset_held", 4'hF, 9'b100000000);
    rst = 1'b0;
    #1;
    check("reset_released", 4'hF, 9'b100000000);
    step(1'b0);
    check("tlr_to_idle", 4'hC, 9'b000000000);

    // Asynchronous reset in the middle of a DR shift.
    step(1'b1); step(1'b0); step(1'b0);
    check("reach_shift_dr", 4'h2, 9'b001010000);
    #2 rst = 1'b1;
    #1 check("async_rst_mid_shift", 4'hF, 9'b100000000);
    #1 rst = 1'b0;
    step(1'b0);
    check("idle_after_rst", 4'hC, 9'b000000000);

    foreach (dr_vec[i]) begin
      step(dr_vec[i].tms);
      check($sformatf("dr_scan[%0d]", i), dr_vec[i].exp_state, dr_vec[i].exp_flags);
    end

    foreach (ir_vec[i]) begin
      step(ir_vec[i].tms);
      check($sformatf("ir_scan[%0d]", i), ir_vec[i].exp_state, ir_vec[i].exp_flags);
    end

    // Five TMS=1 edges reach TEST_LOGIC_RESET from every state.
    for (int p = 0; p < 16; p++) begin
      tms_reset();
      walk(paths[p]);
      check($sformatf("reach_%h", paths[p].target), paths[p].target, exp_flags(paths[p].target));
      tms_reset();
      check($sformatf("tms_reset_from_%h", paths[p].target), 4'hF, 9'b100000000);
    end

    walk(paths[9]);
    step(1'b1);
    check("select_ir_tms1_to_tlr", 4'hF, 9'b100000000);

    // Hold states under TMS=0.
    for (int h = 0; h < 5; h++) begin
      int idx;
      case (h)
        0: idx = 1;
        1: idx = 4;
        2: idx = 6;
        3: idx = 11;
        default: idx = 13;
      endcase
      tms_reset();
      walk(paths[idx]);
      for (int k = 0; k < 10; k++) begin
        step(1'b0);
        check($sformatf("hold_%h[%0d]", paths[idx].target, k), paths[idx].target,
              exp_flags(paths[idx].target));
      end
    end

    // UPDATE_IR with TMS=1 goes straight to SELECT_DR and drops sel.
    tms_reset();
    walk(paths[15]);
    check("reach_update_ir", 4'hD, 9'b010000001);
    step(1'b1);
    check("update_ir_to_select_dr", 4'h7, 9'b000000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
